// File: rtl/vga_sync_decoder.sv
// ----------------------------------------------------------------------------
// vga_sync_decoder
//   Receive-side decoder for the hs/vs/3-bit RGB video stream. It measures line
//   and frame geometry and locks once two consecutive frames agree. While
//   locked it regenerates active-area pixel coordinates and counts lit pixels
//   per frame.
//
// Ports
//   clk         pixel clock
//   rst_n       asynchronous reset, active-low
//   vid_hs      horizontal sync (active level set by HS_POL)
//   vid_vs      vertical sync   (active level set by VS_POL)
//   vid_rgb     {r,g,b} pixel data
//   locked      geometry stable, coordinate outputs valid
//   active      current pixel is inside the H_ACT x V_ACT window (locked only)
//   x_pos       active-area column (0 when !active)
//   y_pos       active-area row    (0 when !active)
//   h_total     last measured clocks per line (0 = invalid / saturated)
//   v_total     last measured lines per frame
//   lit_pixels  lit pixels in the last complete locked frame
//   frame_done  one-cycle pulse when lit_pixels / v_total update while locked
//
// Timing: vid_* are registered once; counters, FSM and outputs are computed
// from that stage and registered, so a pixel at the pins appears on
// active/x_pos/y_pos two clocks later.
// ----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int X_OFFSET = 144,
  parameter int Y_OFFSET = 35,
  parameter int H_ACT    = 640,
  parameter int V_ACT    = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic [2:0]  vid_rgb,
  output logic        locked,
  output logic        active,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [11:0] h_total,
  output logic [10:0] v_total,
  output logic [18:0] lit_pixels,
  output logic        frame_done
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  localparam logic [11:0] H_LO = 12'(X_OFFSET);
  localparam logic [11:0] H_HI = 12'(X_OFFSET + H_ACT);
  localparam logic [10:0] V_LO = 11'(Y_OFFSET);
  localparam logic [10:0] V_HI = 11'(Y_OFFSET + V_ACT);

  // Input stage and sync edge detection
  logic       hs_q, vs_q;
  logic [2:0] rgb_q;
  logic       hs_prev_q;     // normalised hs of the previous cycle
  logic       vs_at_edge_q;  // normalised vs sampled at the previous hs leading edge
  logic       hs_a, vs_a, hs_edge, frame_start;

  // The raw registers reset to the inactive sync level so that reset release
  // never fabricates an hs edge.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q         <= ~HS_POL;
      vs_q         <= ~VS_POL;
      rgb_q        <= '0;
      hs_prev_q    <= 1'b0;
      vs_at_edge_q <= 1'b0;
    end else begin
      hs_q      <= vid_hs;
      vs_q      <= vid_vs;
      rgb_q     <= vid_rgb;
      hs_prev_q <= hs_a;
      if (hs_edge) vs_at_edge_q <= vs_a;
    end
  end

  assign hs_a        = (hs_q == HS_POL);
  assign vs_a        = (vs_q == VS_POL);
  assign hs_edge     = hs_a & ~hs_prev_q;
  assign frame_start = hs_edge & vs_a & ~vs_at_edge_q;

  // Line / frame counters. *_d is the count of the pixel now in the input stage.
  logic [11:0] h_cnt_q, h_cnt_d, h_meas;
  logic [10:0] v_cnt_q, v_cnt_d, v_meas;

  assign h_cnt_d = hs_edge ? 12'd0 : ((&h_cnt_q) ? h_cnt_q : h_cnt_q + 12'd1);
  // A saturated line length is reported as 0 so it can never match a reference.
  assign h_meas  = (&h_cnt_q) ? 12'd0 : h_cnt_q + 12'd1;
  assign v_meas  = v_cnt_q + 11'd1;

  always_comb begin
    v_cnt_d = v_cnt_q;
    if (frame_start)                v_cnt_d = 11'd0;
    else if (hs_edge && !(&v_cnt_q)) v_cnt_d = v_cnt_q + 11'd1;
  end

  // Lock FSM
  state_e      state_q, state_d;
  logic [11:0] ref_h_q;
  logic [10:0] ref_v_q;
  logic        ref_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ref_load = 1'b0;
    case (state_q)
      SEARCH: begin
        if (frame_start) begin
          state_d  = MEASURE;
          ref_load = 1'b1;
        end
      end
      MEASURE: begin
        if (frame_start) begin
          if (h_meas == ref_h_q && v_meas == ref_v_q && h_meas != 12'd0 && v_meas != 11'd0)
            state_d = LOCKED;
          else
            ref_load = 1'b1;
        end
      end
      LOCKED: begin
        if ((hs_edge && h_meas != ref_h_q) || (frame_start && v_meas != ref_v_q))
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state_q == LOCKED);
  end

  // Coordinates and lit-pixel accounting. The window test uses the next state so
  // active and locked always change together.
  logic        in_window, publish;
  logic        active_q, frame_done_q;
  logic [9:0]  x_pos_q, y_pos_q;
  logic [11:0] h_total_q;
  logic [10:0] v_total_q;
  logic [18:0] lit_cnt_q, lit_cnt_d, lit_pixels_q;

  assign in_window = (state_d == LOCKED) &&
                     (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) &&
                     (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);

  // A frame start that also drops lock must not publish the count.
  assign publish = frame_start && (state_q == LOCKED) && (state_d == LOCKED);

  always_comb begin
    lit_cnt_d = lit_cnt_q;
    if (frame_start)
      lit_cnt_d = 19'd0;
    else if (in_window && rgb_q != 3'd0 && !(&lit_cnt_q))
      lit_cnt_d = lit_cnt_q + 19'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      ref_h_q      <= '0;
      ref_v_q      <= '0;
      active_q     <= 1'b0;
      x_pos_q      <= '0;
      y_pos_q      <= '0;
      h_total_q    <= '0;
      v_total_q    <= '0;
      lit_cnt_q    <= '0;
      lit_pixels_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      lit_cnt_q    <= lit_cnt_d;
      active_q     <= in_window;
      x_pos_q      <= in_window ? 10'(h_cnt_d - H_LO) : 10'd0;
      y_pos_q      <= in_window ? 10'(v_cnt_d - V_LO) : 10'd0;
      frame_done_q <= publish;
      if (ref_load) begin
        ref_h_q <= h_meas;
        ref_v_q <= v_meas;
      end
      if (hs_edge)     h_total_q    <= h_meas;
      if (frame_start) v_total_q    <= v_meas;
      if (publish)     lit_pixels_q <= lit_cnt_q;
    end
  end

  assign active     = active_q;
  assign x_pos      = x_pos_q;
  assign y_pos      = y_pos_q;
  assign h_total    = h_total_q;
  assign v_total    = v_total_q;
  assign lit_pixels = lit_pixels_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_decoder
//   Drives a reduced video timing (26 x 13 total, 16 x 8 active) into two
//   decoders: one with active-low syncs, one with active-high syncs fed the
//   inverted stream. Both are compared every cycle against a pixel-stream
//   reference model, with directed checks on lock timing, coordinates and
//   lit-pixel counts.
// ----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int XO  = 6;
  localparam int YO  = 3;
  localparam int HA  = 16;
  localparam int VA  = 8;
  localparam int HT  = 26;
  localparam int VT  = 13;
  localparam int HSW = 3;
  localparam int VSW = 2;

  localparam int ST_SEARCH = 0;
  localparam int ST_MEAS   = 1;
  localparam int ST_LOCKED = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Normalised stimulus (1 = sync active); each DUT gets its own polarity.
  logic       hs_a_drv, vs_a_drv;
  logic [2:0] rgb_drv;
  logic       vid_hs0, vid_vs0, vid_hs1, vid_vs1;
  assign vid_hs0 = ~hs_a_drv;
  assign vid_vs0 = ~vs_a_drv;
  assign vid_hs1 = hs_a_drv;
  assign vid_vs1 = vs_a_drv;

  logic [1:0]  locked, active, frame_done;
  logic [9:0]  x_pos   [2];
  logic [9:0]  y_pos   [2];
  logic [11:0] h_total [2];
  logic [10:0] v_total [2];
  logic [18:0] lit     [2];

  vga_sync_decoder #(
    .HS_POL(1'b0), .VS_POL(1'b0),
    .X_OFFSET(XO), .Y_OFFSET(YO), .H_ACT(HA), .V_ACT(VA)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .vid_hs(vid_hs0), .vid_vs(vid_vs0), .vid_rgb(rgb_drv),
    .locked(locked[0]), .active(active[0]),
    .x_pos(x_pos[0]), .y_pos(y_pos[0]),
    .h_total(h_total[0]), .v_total(v_total[0]),
    .lit_pixels(lit[0]), .frame_done(frame_done[0])
  );

  vga_sync_decoder #(
    .HS_POL(1'b1), .VS_POL(1'b1),
    .X_OFFSET(XO), .Y_OFFSET(YO), .H_ACT(HA), .V_ACT(VA)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .vid_hs(vid_hs1), .vid_vs(vid_vs1), .vid_rgb(rgb_drv),
    .locked(locked[1]), .active(active[1]),
    .x_pos(x_pos[1]), .y_pos(y_pos[1]),
    .h_total(h_total[1]), .v_total(v_total[1]),
    .lit_pixels(lit[1]), .frame_done(frame_done[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (one step per pixel) ----------------
  typedef struct {
    bit locked;
    bit active;
    int x;
    int y;
    int ht;
    int vt;
    int lit;
    bit fd;
  } exp_t;

  exp_t m_out;
  exp_t zero_out;
  exp_t pipe [2];
  bit   mark [2];
  bit   m_prev_hs, m_vs_edge;
  int   m_h, m_v, m_st, m_ref_h, m_ref_v, m_lit;

  function automatic void model_reset();
    m_prev_hs = 0; m_vs_edge = 0;
    m_h = 0; m_v = 0; m_st = ST_SEARCH; m_ref_h = 0; m_ref_v = 0; m_lit = 0;
    m_out = '{default: 0};
  endfunction

  function automatic void model_step(bit hs, bit vs, logic [2:0] rgb);
    bit e_hs, fs, was_locked;
    int htn, vtn;
    e_hs = hs && !m_prev_hs;
    m_prev_hs = hs;
    fs = e_hs && vs && !m_vs_edge;
    if (e_hs) m_vs_edge = vs;
    htn = (m_h == 4095) ? 0 : m_h + 1;
    vtn = (m_v + 1) % 2048;
    m_h = e_hs ? 0 : ((m_h < 4095) ? m_h + 1 : 4095);
    if (fs) m_v = 0;
    else if (e_hs && m_v < 2047) m_v = m_v + 1;
    if (e_hs) m_out.ht = htn;
    if (fs)   m_out.vt = vtn;
    was_locked = (m_st == ST_LOCKED);
    if (m_st == ST_SEARCH) begin
      if (fs) begin m_st = ST_MEAS; m_ref_h = htn; m_ref_v = vtn; end
    end else if (m_st == ST_MEAS) begin
      if (fs) begin
        if (htn == m_ref_h && vtn == m_ref_v && htn != 0 && vtn != 0) m_st = ST_LOCKED;
        else begin m_ref_h = htn; m_ref_v = vtn; end
      end
    end else begin
      if ((e_hs && htn != m_ref_h) || (fs && vtn != m_ref_v)) m_st = ST_SEARCH;
    end
    m_out.locked = (m_st == ST_LOCKED);
    m_out.active = m_out.locked && m_h >= XO && m_h < XO + HA && m_v >= YO && m_v < YO + VA;
    m_out.x  = m_out.active ? m_h - XO : 0;
    m_out.y  = m_out.active ? m_v - YO : 0;
    m_out.fd = 0;
    if (fs) begin
      if (was_locked && m_out.locked) begin
        m_out.lit = m_lit;
        m_out.fd  = 1;
      end
      m_lit = 0;
    end else if (m_out.active && rgb != 3'd0 && m_lit < 524287) begin
      m_lit = m_lit + 1;
    end
  endfunction

  task automatic compare_outputs(input exp_t e);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("coord%0d", i),
            {locked[i], active[i], x_pos[i], y_pos[i]},
            {e.locked, e.active, 10'(e.x), 10'(e.y)});
      check($sformatf("meas%0d", i),
            {h_total[i], v_total[i], lit[i], frame_done[i]},
            {12'(e.ht), 11'(e.vt), 19'(e.lit), e.fd});
    end
  endtask

  // ---------------- stimulus ----------------
  int fs_count;
  bit lock_probe;
  int exp_lit;

  // At each falling edge: check what the DUT shows for the pixel driven two
  // cycles ago, then drive the next pixel.
  task automatic pix(input bit hs, input bit vs, input logic [2:0] rgb, input bit mk);
    @(negedge clk);
    compare_outputs(pipe[1]);
    if (mark[1])
      check("lit_pixel_coord", {active[0], x_pos[0], y_pos[0]}, {1'b1, 10'd10, 10'd5});
    if (lock_probe && locked[0]) begin
      check("lock_at_frame_start", 64'(fs_count), 64'd3);
      lock_probe = 0;
    end
    if (frame_done[0] && exp_lit >= 0) begin
      check("lit_pixels", 64'(lit[0]), 64'(exp_lit));
      exp_lit = -1;
    end
    pipe[1] = pipe[0];
    mark[1] = mark[0];
    hs_a_drv = hs;
    vs_a_drv = vs;
    rgb_drv  = rgb;
    model_step(hs, vs, rgb);
    pipe[0] = m_out;
    mark[0] = mk;
  endtask

  // mode: 0 black, 1 random, 2 white window, 3 single lit pixel at (10,5)
  task automatic frame(input int mode, input int stretch_line, input int skip, input int max_pix);
    int n;
    n = 0;
    for (int l = 0; l < VT; l++) begin
      int len;
      len = HT + ((l == stretch_line) ? 1 : 0);
      for (int c = 0; c < len; c++) begin
        bit inwin, mk;
        logic [2:0] rgb;
        if (n >= max_pix) return;
        n++;
        if (n > skip) begin
          inwin = (c >= XO) && (c < XO + HA) && (l >= YO) && (l < YO + VA);
          mk = 0;
          case (mode)
            0: rgb = 3'd0;
            1: rgb = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            2: rgb = inwin ? 3'd7 : 3'($urandom_range(0, 7));
            default: begin
              mk  = (l == YO + 5) && (c == XO + 10);
              rgb = mk ? 3'b101 : 3'd0;
            end
          endcase
          if (mk) exp_lit = 1;
          if (mode == 2 && l == YO && c == XO) exp_lit = HA * VA;
          if (l == 0 && c == 0) fs_count++;
          pix(c < HSW, l < VSW, rgb, mk);
        end
      end
    end
  endtask

  task automatic idle_pins();
    hs_a_drv = 0;
    vs_a_drv = 0;
    rgb_drv  = 3'd0;
  endtask

  task automatic prepare_reset_state();
    model_reset();
    pipe[0] = zero_out; pipe[1] = zero_out;
    mark[0] = 0; mark[1] = 0;
    fs_count = 0; lock_probe = 1; exp_lit = -1;
  endtask

  // Release at a falling edge. The first rising edge afterwards processes the
  // reset contents of the input register (an idle pixel) and captures the pins.
  task automatic release_reset(input bit first_fs);
    @(negedge clk);
    compare_outputs(zero_out);
    rst_n = 1;
    if (first_fs) begin
      hs_a_drv = 1; vs_a_drv = 1; rgb_drv = 3'd0;
      fs_count = 1;
    end
    model_step(0, 0, 3'd0);
    pipe[1] = m_out;
    model_step(hs_a_drv, vs_a_drv, rgb_drv);
    pipe[0] = m_out;
  endtask

  initial begin
    zero_out = '{default: 0};
    rst_n = 0;
    idle_pins();
    prepare_reset_state();
    repeat (4) @(negedge clk);
    release_reset(0);

    // Clean timing, black picture: lock at the third frame start.
    repeat (4) frame(0, -1, 0, 1 << 20);
    check("locked_clean", 64'(locked[0]), 64'd1);
    check("h_total_clean", 64'(h_total[0]), 64'(HT));
    check("v_total_clean", 64'(v_total[0]), 64'(VT));

    // Single lit pixel, then random content.
    frame(3, -1, 0, 1 << 20);
    frame(0, -1, 0, 1 << 20);
    repeat (2) frame(1, -1, 0, 1 << 20);

    // One stretched line drops lock; clean frames relock.
    frame(1, 6, 0, 1 << 20);
    check("unlock_stretch", 64'(locked[0]), 64'd0);
    repeat (3) frame(1, -1, 0, 1 << 20);
    check("relock_stretch", 64'(locked[0]), 64'd1);

    // Full white window, then hs held inactive long enough to saturate.
    frame(2, -1, 0, 1 << 20);
    frame(0, -1, 0, 1 << 20);
    repeat (5000) pix(0, 0, 3'($urandom_range(0, 7)), 0);
    frame(0, -1, 0, 1 << 20);
    check("unlock_saturate", 64'(locked[0]), 64'd0);
    repeat (3) frame(1, -1, 0, 1 << 20);

    // Asynchronous reset mid-line while locked.
    check("locked_before_reset", 64'(locked[0]), 64'd1);
    frame(1, -1, 0, HT * 5 + 9);
    #3 rst_n = 0;
    #1 compare_outputs(zero_out);
    idle_pins();
    prepare_reset_state();
    repeat (3) @(negedge clk);
    release_reset(1);
    frame(0, -1, 1, 1 << 20);
    repeat (3) frame(0, -1, 0, 1 << 20);
    check("relock_after_reset", 64'(locked[0]), 64'd1);

    // Random content with occasional stretched lines.
    repeat (6) frame(1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, VT - 1)) : -1, 0, 1 << 20);
    repeat (2) pix(0, 0, 3'd0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
